// File: rtl/inverse_lifting.sv
// Inverse 5/3 lifting: rebuilds the interleaved sample stream (even, odd, ...)
// from coarse/detail coefficient pairs, one frame at a time.
module inverse_lifting #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] coarse_in,
    input  logic [DATA_W-1:0] detail_in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int unsigned SUM_W = DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        ODD_PREV = 3'd2,
        EVEN     = 3'd3,
        ODD_LAST = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cur_e_q, cur_e_d;
    logic [DATA_W-1:0] cur_d_q, cur_d_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] pend_e_q, pend_e_d;
    logic [DATA_W-1:0] pend_d_q, pend_d_d;
    logic [DATA_W-1:0] prev_d_q, prev_d_d;

    logic              accept_c;
    logic [DATA_W-1:0] e_new;
    logic [SUM_W-1:0]  e_sum;
    logic [DATA_W-1:0] odd_prev;
    logic [DATA_W-1:0] odd_last;

    // Lifting arithmetic; the e[n-1]+e[n] sum keeps its carry before halving.
    assign accept_c = in_valid && in_ready;
    assign e_new    = coarse_in - ((prev_d_q >> 2) + (detail_in >> 2));
    assign e_sum    = SUM_W'(pend_e_q) + SUM_W'(cur_e_q);
    assign odd_prev = pend_d_q + DATA_W'(e_sum >> 1);
    assign odd_last = cur_d_q + cur_e_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cur_e_q  <= '0;
            cur_d_q  <= '0;
            last_q   <= 1'b0;
            pend_e_q <= '0;
            pend_d_q <= '0;
            prev_d_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_e_q  <= cur_e_d;
            cur_d_q  <= cur_d_d;
            last_q   <= last_d;
            pend_e_q <= pend_e_d;
            pend_d_q <= pend_d_d;
            prev_d_q <= prev_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_e_d  = cur_e_q;
        cur_d_d  = cur_d_q;
        last_d   = last_q;
        pend_e_d = pend_e_q;
        pend_d_d = pend_d_q;
        prev_d_d = prev_d_q;
        case (state_q)
            IDLE, WAIT: begin
                if (accept_c) begin
                    cur_e_d = e_new;
                    cur_d_d = detail_in;
                    last_d  = in_last;
                    state_d = (state_q == IDLE) ? EVEN : ODD_PREV;
                end
            end
            ODD_PREV: begin
                if (out_ready) begin
                    state_d = EVEN;
                end
            end
            EVEN: begin
                if (out_ready) begin
                    pend_e_d = cur_e_q;
                    pend_d_d = cur_d_q;
                    prev_d_d = cur_d_q;
                    state_d  = last_q ? ODD_LAST : WAIT;
                end
            end
            ODD_LAST: begin
                if (out_ready) begin
                    prev_d_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs, all forced quiet while reset is held.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        sample_out = '0;
        if (rst) begin
            case (state_q)
                IDLE, WAIT: in_ready = 1'b1;
                ODD_PREV: begin
                    out_valid  = 1'b1;
                    sample_out = odd_prev;
                end
                EVEN: begin
                    out_valid  = 1'b1;
                    sample_out = cur_e_q;
                end
                ODD_LAST: begin
                    out_valid  = 1'b1;
                    out_last   = 1'b1;
                    sample_out = odd_last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_lifting.sv
// Bench for inverse_lifting: directed frames plus random frames with random
// gaps and backpressure, scored against a frame-level 5/3 reference model.
module tb_inverse_lifting;

    localparam int unsigned DW   = 16;
    localparam int          MASK = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] coarse_in = '0;
    logic [DW-1:0] detail_in = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] sample_out;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;

    typedef struct {
        int val;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   fc[16];
    int   fd[16];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit   hold_q = 1'b0;
    int   hold_val = 0;
    bit   hold_last = 1'b0;

    inverse_lifting #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .coarse_in  (coarse_in),
        .detail_in  (detail_in),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .sample_out (sample_out),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-frame inverse lifting on plain integers.
    task automatic model_frame(input int n);
        int e[16];
        int o;
        int dprev;
        int enext;
        for (int i = 0; i < n; i++) begin
            dprev = (i == 0) ? 0 : fd[i-1];
            e[i]  = (fc[i] - (dprev >> 2) - (fd[i] >> 2)) & MASK;
        end
        for (int i = 0; i < n; i++) begin
            enext = (i == n - 1) ? e[i] : e[i+1];
            o     = (fd[i] + ((e[i] + enext) >> 1)) & MASK;
            exp_q.push_back('{val: e[i], last: 1'b0});
            exp_q.push_back('{val: o, last: (i == n - 1)});
        end
    endtask

    task automatic push_exp(input int v, input bit l);
        exp_q.push_back('{val: v, last: l});
    endtask

    // Called at posedge+1; returns at posedge+1 after the last pair is accepted.
    task automatic send_frame(input int n, input bit gaps, input bit keep, input bit use_model);
        int g;
        int t;
        if (use_model) model_frame(n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            coarse_in = DW'(fc[i]);
            detail_in = DW'(fd[i]);
            in_last   = (i == n - 1);
            in_valid  = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 60) begin
                @(negedge clk);
                t++;
            end
            check_eq("accept", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        if (!keep) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'(($urandom_range(0, 3)) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Output scoreboard and stall-stability monitor.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_sample", 32'(sample_out), 32'(hold_val));
                check_eq("hold_last", 32'(out_last), 32'(hold_last));
            end
            if (!out_valid) check_eq("idle_zero", 32'(sample_out), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(sample_out), 32'hFFFF_FFFF);
                end else begin
                    x = exp_q.pop_front();
                    check_eq("sample", 32'(sample_out), 32'(x.val));
                    check_eq("last", 32'(out_last), 32'(x.last));
                end
            end
            hold_q    = out_valid && !out_ready;
            hold_val  = int'(sample_out);
            hold_last = out_last;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sample", 32'(sample_out), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single pair
        fc[0] = 100; fd[0] = 8;
        push_exp(98, 1'b0); push_exp(106, 1'b1);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        drain("drain_single");

        // Two pairs with a 3-cycle stall in the first odd output
        fc[0] = 100; fd[0] = 8; fc[1] = 200; fd[1] = 12;
        push_exp(98, 1'b0); push_exp(154, 1'b0); push_exp(195, 1'b0); push_exp(207, 1'b1);
        fork
            send_frame(2, 1'b0, 1'b0, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (!(out_valid && out_ready && sample_out == DW'(98)) && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                rdy_mode = 2;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 3; k++) begin
                    check_eq("stall_sample", 32'(sample_out), 32'd154);
                    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                    if (k < 2) @(negedge clk);
                end
                rdy_mode = 0;
            end
        join
        drain("drain_stall");

        // Modulo wrap
        fc[0] = 0; fd[0] = 16;
        push_exp(65532, 1'b0); push_exp(12, 1'b1);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        drain("drain_wrap");

        // Reset mid-frame discards the pending pair
        rdy_mode = 2;
        @(posedge clk);
        #1;
        coarse_in = 16'd100; detail_in = 16'd8; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check_eq("mid_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_sample", 32'(sample_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rel_valid", 32'(out_valid), 32'd0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        fc[0] = 50; fd[0] = 0;
        push_exp(50, 1'b0); push_exp(50, 1'b1);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        drain("drain_reset");

        // Back-to-back frames with in_valid held
        fc[0] = 100; fd[0] = 8;
        push_exp(98, 1'b0); push_exp(106, 1'b1);
        send_frame(1, 1'b0, 1'b1, 1'b0);
        push_exp(98, 1'b0); push_exp(106, 1'b1);
        send_frame(1, 1'b0, 1'b0, 1'b0);
        drain("drain_b2b");

        // Random frames, random gaps and backpressure
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                fc[i] = int'($urandom_range(0, MASK));
                fd[i] = int'($urandom_range(0, MASK));
            end
            send_frame(n, 1'b1, 1'b0, 1'b1);
        end
        drain("drain_random");
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inverse_lifting.md
INVERSE_LIFTING -- requirements
Module: inverse_lifting

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample and coefficient width.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-004 SHALL have port coarse_in  input  DATA_W  coarse coefficient c[n].
REQ-005 SHALL have port detail_in  input  DATA_W  detail coefficient d[n].
REQ-006 SHALL have port in_valid  input  1  coefficient pair present.
REQ-007 SHALL have port in_last  input  1  pair is last of frame; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  block accepts pair this cycle.
REQ-009 SHALL have port sample_out  output  DATA_W  reconstructed sample.
REQ-010 SHALL have port out_valid  output  1  sample_out valid.
REQ-011 SHALL have port out_last  output  1  final sample of frame; qualified by out_valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts sample.

Function
REQ-013 SHALL accept a pair only when in_valid && in_ready, and emit a sample only when out_valid && out_ready.
REQ-014 SHALL invert the 5/3 lifting: e[n] = c[n] - ((d[n-1]>>2) + (d[n]>>2)); o[n] = d[n] + ((e[n] + e[n+1])>>1).
REQ-015 SHALL use logical right shifts and unsigned modulo-2^DATA_W add/subtract; the e[n]+e[n+1] sum SHALL be DATA_W+1 bits wide before the shift, and the result SHALL be truncated to DATA_W.
REQ-016 SHALL treat d[-1] as 0 at the start of every frame.
REQ-017 SHALL treat e[N] as e[N-1] on the last pair, so the last odd sample is d[N-1] + e[N-1].
REQ-018 SHALL emit samples in the order e[0], o[0], e[1], o[1], ..., e[N-1], o[N-1], and SHALL produce exactly 2 outputs per input pair.
REQ-019 SHALL implement FSM states IDLE, WAIT, ODD_PREV, EVEN, ODD_LAST.
REQ-020 IDLE: in_ready=1, out_valid=0; on accept, register e[n], d[n] and last; go to EVEN.
REQ-021 WAIT: holds pending e[n-1], d[n-1]; in_ready=1, out_valid=0; on accept, compute e[n]; go to ODD_PREV.
REQ-022 ODD_PREV: out_valid=1, sample_out=o[n-1], out_last=0; on out_ready, go to EVEN.
REQ-023 EVEN: out_valid=1, sample_out=e[n], out_last=0; on out_ready, go to ODD_LAST if last else WAIT, with pending <- e[n], d[n] and prev_d <- d[n].
REQ-024 ODD_LAST: out_valid=1, sample_out=o[n], out_last=1; on out_ready, clear prev_d to 0 and go to IDLE.
REQ-025 in_ready SHALL be 0 in ODD_PREV, EVEN and ODD_LAST.
REQ-026 sample_out and out_last SHALL stay stable while out_valid && !out_ready.
REQ-027 A one-pair frame (in_last on the first pair) SHALL follow IDLE -> EVEN -> ODD_LAST -> IDLE.
REQ-028 Back-to-back frames SHALL need no idle cycle between them beyond the return to IDLE.
REQ-029 sample_out SHALL be 0 whenever out_valid=0.

Reset
REQ-030 While rst=0 at a clock edge: state <- IDLE; pending e, pending d and prev_d <- 0; out_valid=0, out_last=0, sample_out=0, in_ready=0.
REQ-031 Reset mid-frame SHALL discard all pending data without emitting a partial sample; in_ready SHALL return to 1 on the first cycle with rst=1.

Verification
REQ-032 Single pair c=100, d=8, last=1 -> outputs 98 then 106; out_last only on 106.
REQ-033 Two pairs (100,8), (200,12,last) -> outputs 98, 154, 195, 207; out_last on 207.
REQ-034 Hold out_ready=0 for 3 cycles in ODD_PREV -> sample_out stays 154, in_ready stays 0, no input accepted; resumes correctly afterwards.
REQ-035 Wrap: c=0, d=16, last=1 -> outputs 65532 then 12.
REQ-036 Drive rst=0 for 1 cycle after the first pair of a 2-pair frame, then send c=50, d=0, last=1 -> only outputs 50, 50; no stale sample appears.
REQ-037 Send frame (100,8,last) then immediately (100,8,last) -> second frame outputs 98, 106 again (prev_d cleared); in_valid is held continuously.
